perf_event_counter: RTL and testbench

//  Parametrised pipeline performance monitor for the CPU core. Counts run cycles plus NUM_EVT
//  per-cycle event strobes (stall, flush, retire, branch, ...), halts at a programmable cycle

---
 rtl/perf_pkg.sv | 16 +
 rtl/perf_cnt_cell.sv | 50 +++++
 rtl/perf_event_counter.sv | 100 ++++++++++
 tb/tb_perf_event_counter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types for the pipeline performance monitor: FSM state encoding and
// the event channel indices used by the core's hazard/control strobes.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } perf_state_e;

    localparam int EVT_STALL  = 0;
    localparam int EVT_FLUSH  = 1;
    localparam int EVT_RETIRE = 2;
    localparam int EVT_BRANCH = 3;

endpackage

// File: rtl/perf_cnt_cell.sv
// One live counter with sticky overflow flag. Build option PERF_SAT_EN selects
// saturate-at-max; otherwise the counter wraps modulo 2^CNT_W.
module perf_cnt_cell #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
`ifdef PERF_SAT_EN
            // Hold at all-ones; the first refused increment raises the flag.
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + ONE;
`else
            cnt_d = cnt_q + ONE;
            if (&cnt_q) ovf_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_event_counter.sv
// Pipeline performance monitor: run-cycle counter plus NUM_EVT event channels,
// cycle-limit halt and 4-phase snapshot readout. Build option: PERF_SAT_EN.
//
//   state   | meaning
//   IDLE    | not counting; counts retained
//   RUN     | cycle counter and enabled events count every edge
//   HALTED  | cycle limit reached; frozen until clr_i
module perf_event_counter
    import perf_pkg::*;
#(
    parameter  int NUM_EVT = 4,
    parameter  int CNT_W   = 32,
    localparam int SEL_W   = $clog2(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               clr_i,
    input  logic [CNT_W-1:0]   limit_i,
    input  logic [NUM_EVT-1:0] event_i,
    input  logic               snap_req_i,
    output logic               snap_ack_o,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic [1:0]         state_o,
    output logic               halt_o
);

    localparam int               NCH     = NUM_EVT + 1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_EVT);

    perf_state_e      state_q, state_d;
    logic             ack_q;
    logic [CNT_W-1:0] live [NCH];
    logic [CNT_W-1:0] shadow_q [NCH];
    logic [NCH-1:0]   inc;
    logic             run, capture, lim_hit;

    assign run     = (state_q == ST_RUN);
    assign capture = snap_req_i & ~ack_q;
    assign inc     = {NCH{run}} & {event_i, 1'b1};
    // Halt on the edge whose increment lands exactly on the limit.
    assign lim_hit = (limit_i != '0) && ((live[0] + ONE) == limit_i);

    for (genvar k = 0; k < NCH; k++) begin : g_cell
        perf_cnt_cell #(.CNT_W(CNT_W)) u_cell (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .clr_i   (clr_i),
            .inc_i   (inc[k]),
            .cnt_o   (live[k]),
            .ovf_o   (ovf_o[k])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_RUN;
            ST_RUN: begin
                if (lim_hit)       state_d = ST_HALTED;
                else if (!start_i) state_d = ST_IDLE;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
        if (clr_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= snap_req_i;
        end
    end

    // Shadows take the pre-edge live values, so a same-edge clear still captures.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NCH; k++) shadow_q[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < NCH; k++) shadow_q[k] <= live[k];
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (rd_sel_i <= SEL_MAX) rd_data_o = shadow_q[rd_sel_i];
    end

    assign snap_ack_o = ack_q;
    assign state_o    = state_q;
    assign halt_o     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_perf_event_counter.sv
// Directed bench for perf_event_counter: a 32-bit instance for the main flows
// and a 4-bit instance for wrap/saturation behaviour.
module tb_perf_event_counter;
    import perf_pkg::*;

    localparam int NE = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0, clr_i = 1'b0, snap_req_i = 1'b0;
    logic [31:0]   limit_i = '0;
    logic [NE-1:0] event_i = '0;
    logic [2:0]    rd_sel_i = '0;
    logic          snap_ack_o, halt_o;
    logic [31:0]   rd_data_o;
    logic [NE:0]   ovf_o;
    logic [1:0]    state_o;

    logic          start4 = 1'b0, snap4 = 1'b0;
    logic [2:0]    rd_sel4 = '0;
    logic          ack4, halt4;
    logic [3:0]    rd_data4;
    logic [NE:0]   ovf4;
    logic [1:0]    state4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    perf_event_counter #(.NUM_EVT(NE), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .clr_i(clr_i),
        .limit_i(limit_i), .event_i(event_i), .snap_req_i(snap_req_i),
        .snap_ack_o(snap_ack_o), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o),
        .ovf_o(ovf_o), .state_o(state_o), .halt_o(halt_o)
    );

    perf_event_counter #(.NUM_EVT(NE), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start4), .clr_i(1'b0),
        .limit_i(4'd0), .event_i(4'b0000), .snap_req_i(snap4),
        .snap_ack_o(ack4), .rd_sel_i(rd_sel4), .rd_data_o(rd_data4),
        .ovf_o(ovf4), .state_o(state4), .halt_o(halt4)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] sel, input string tag, input logic [31:0] exp);
        rd_sel_i = sel;
        #1;
        chk(tag, rd_data_o, exp);
    endtask

    task automatic snap();
        snap_req_i = 1'b1;
        tick(1);
        snap_req_i = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #3;
        chk("rst_state", state_o, 2'd0);
        chk("rst_halt", halt_o, 1'b0);
        chk("rst_ack", snap_ack_o, 1'b0);
        chk("rst_ovf", ovf_o, '0);
        chk("rst_rd", rd_data_o, 32'd0);
        #9 rst_n_i = 1'b1;
        tick(1);

        // 10 run cycles, stall strobe every other cycle
        start_i = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            start_i = (i != 9);
            event_i[EVT_STALL] = (i % 2 == 0);
            tick(1);
        end
        event_i = '0;
        chk("t1_idle", state_o, 2'd0);
        snap_req_i = 1'b1;
        tick(1);
        chk("t1_ack_hi", snap_ack_o, 1'b1);
        rd(3'd0, "t1_ch0", 32'd10);
        rd(3'd1, "t1_ch1", 32'd5);
        rd(3'd2, "t1_ch2", 32'd0);
        rd(3'd7, "t1_sel_oob", 32'd0);
        snap_req_i = 1'b0;
        tick(1);
        chk("t1_ack_lo", snap_ack_o, 1'b0);

        // Capture while counters keep running
        start_i = 1'b1;
        event_i = 4'b1111;
        tick(4);
        snap_req_i = 1'b1;
        chk("t3_ack_pre", snap_ack_o, 1'b0);
        tick(1);
        chk("t3_ack_rise", snap_ack_o, 1'b1);
        tick(2);
        chk("t3_ack_held", snap_ack_o, 1'b1);
        chk("t3_running", state_o, 2'd1);
        rd(3'd0, "t3_sh0", 32'd13);
        rd(3'd1, "t3_sh1", 32'd8);
        rd(3'd4, "t3_sh4", 32'd3);
        snap_req_i = 1'b0;
        #1;
        chk("t3_ack_still", snap_ack_o, 1'b1);
        tick(1);
        chk("t3_ack_fall", snap_ack_o, 1'b0);
        rd(3'd0, "t3_sh0_frozen", 32'd13);
        start_i = 1'b0;
        event_i = '0;
        tick(1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        chk("t4_clr_idle", state_o, 2'd0);

        // Clear and capture on the same edge with ch0 = 7
        start_i = 1'b1;
        tick(1);
        for (int i = 0; i < 7; i++) begin
            start_i = (i != 6);
            tick(1);
        end
        clr_i = 1'b1;
        snap_req_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        snap_req_i = 1'b0;
        rd(3'd0, "t4_shadow7", 32'd7);
        tick(1);
        snap();
        rd(3'd0, "t4_live0", 32'd0);

        // Cycle limit of 20
        limit_i = 32'd20;
        start_i = 1'b1;
        event_i[EVT_FLUSH] = 1'b1;
        tick(1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (i == 18) begin
                chk("t2_nohalt19", halt_o, 1'b0);
                chk("t2_run19", state_o, 2'd1);
            end
        end
        chk("t2_halt", halt_o, 1'b1);
        chk("t2_state_h", state_o, 2'd2);
        tick(5);
        snap();
        rd(3'd0, "t2_ch0", 32'd20);
        rd(3'd2, "t2_ch2", 32'd20);
        rd(3'd1, "t2_ch1", 32'd0);
        chk("t2_still_halt", halt_o, 1'b1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        chk("t2_clr_idle", state_o, 2'd0);
        chk("t2_clr_nohalt", halt_o, 1'b0);
        tick(1);
        chk("t2_start_after_clr", state_o, 2'd1);
        start_i = 1'b0;
        event_i = '0;
        limit_i = '0;
        tick(1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;

        // 4-bit instance, 17 run cycles
        start4 = 1'b1;
        tick(1);
        for (int i = 0; i < 17; i++) begin
            start4 = (i != 16);
            tick(1);
            if (i == 14) chk("t5_ovf_at15", ovf4, '0);
        end
        snap4 = 1'b1;
        tick(1);
        snap4 = 1'b0;
        tick(1);
        rd_sel4 = 3'd0;
        #1;
`ifdef PERF_SAT_EN
        chk("t5_ch0", rd_data4, 4'd15);
`else
        chk("t5_ch0", rd_data4, 4'd1);
`endif
        chk("t5_ovf", ovf4, 5'b00001);

        // Asynchronous reset mid-run and mid-handshake
        start_i = 1'b1;
        event_i = 4'b0101;
        tick(3);
        snap_req_i = 1'b1;
        tick(1);
        chk("t6_pre_ack", snap_ack_o, 1'b1);
        #2 rst_n_i = 1'b0;
        #1;
        rd_sel_i = 3'd0;
        #1;
        chk("t6_state", state_o, 2'd0);
        chk("t6_ack", snap_ack_o, 1'b0);
        chk("t6_rd", rd_data_o, 32'd0);
        chk("t6_ovf4", ovf4, '0);
        tick(1);
        chk("t6_no_capture", rd_data_o, 32'd0);
        start_i = 1'b0;
        snap_req_i = 1'b0;
        event_i = '0;
        rst_n_i = 1'b1;
        tick(1);
        chk("t6_idle_after", state_o, 2'd0);
        snap();
        rd(3'd0, "t6_live_zero", 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
